// File: rtl/adc32_pipe.sv
// adc32_pipe: two-stage pipelined 32-bit add/subtract unit.
//
// The low 16 bits are added in stage 1 and the resulting carry (c16) is
// registered. The high 16 bits and the flags are produced in stage 2 and
// land in the output register. Valid/ready handshakes on both sides.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (a, b, op, cin)
//   op                   00 ADD, 01 ADC, 10 SUB, 11 SBB
//   out_valid/out_ready  result handshake (sum, flags = {N, Z, C, V})
//
// Build option: define ADC32_FLAGS_EN to compute and register N/Z/C/V.
// Without it, flags reads 4'b0000 and the flag logic is absent.

// 16-bit carry-lookahead adder: four 4-bit lookahead groups with a
// lookahead carry network across the groups. gm/pm are the slice-level
// generate/propagate terms.
module add16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        ci,
    output logic [15:0] s,
    output logic        gm,
    output logic        pm
);
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [3:0]  cg;

    assign g = a & b;
    assign p = a ^ b;

    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_grp
            assign gg[k] = g[4*k+3]
                         | (p[4*k+3] & g[4*k+2])
                         | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                         | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            assign gp[k] = &p[4*k +: 4];

            assign c[4*k]   = cg[k];
            assign c[4*k+1] = g[4*k] | (p[4*k] & cg[k]);
            assign c[4*k+2] = g[4*k+1]
                            | (p[4*k+1] & g[4*k])
                            | (p[4*k+1] & p[4*k] & cg[k]);
            assign c[4*k+3] = g[4*k+2]
                            | (p[4*k+2] & g[4*k+1])
                            | (p[4*k+2] & p[4*k+1] & g[4*k])
                            | (p[4*k+2] & p[4*k+1] & p[4*k] & cg[k]);
        end
    endgenerate

    assign cg[0] = ci;
    assign cg[1] = gg[0] | (gp[0] & ci);
    assign cg[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & ci);
    assign cg[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                 | (gp[2] & gp[1] & gp[0] & ci);

    assign gm = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0]);
    assign pm = &gp;

    assign s = p ^ c;
endmodule

module adc32_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  op,
    input  logic        cin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] sum,
    output logic [3:0]  flags
);
    // Stage-1 registers. The high operand halves are split into the sign
    // bit (sa/sb) and bits 30:16 so the sign registers feed both the high
    // adder and the overflow flag.
    logic        s1_valid_q, s1_valid_d;
    logic [15:0] lo_sum_q,   lo_sum_d;
    logic        c16_q,      c16_d;
    logic [14:0] a_hi_q,     a_hi_d;
    logic [14:0] b_hi_q,     b_hi_d;
    logic        sa_q,       sa_d;
    logic        sb_q,       sb_d;

    // Output registers.
    logic        out_valid_q, out_valid_d;
    logic [31:0] sum_q,       sum_d;

    logic [31:0] b_mod;
    logic        c0;
    logic [15:0] lo_s;
    logic        lo_gm;
    logic        lo_pm;
    logic [15:0] hi_s;
    logic        s2_free;
    logic        s1_adv;
    logic        accept;

    // SUB/SBB invert B; ADC/SBB take cin, ADD forces 0, SUB forces 1.
    assign b_mod = op[1] ? ~b : b;
    assign c0    = op[0] ? cin : op[1];

    add16 u_lo (
        .a  (a[15:0]),
        .b  (b_mod[15:0]),
        .ci (c0),
        .s  (lo_s),
        .gm (lo_gm),
        .pm (lo_pm)
    );

`ifdef ADC32_FLAGS_EN
    logic       hi_gm;
    logic       hi_pm;
    logic [3:0] flags_q, flags_d;

    add16 u_hi (
        .a  ({sa_q, a_hi_q}),
        .b  ({sb_q, b_hi_q}),
        .ci (c16_q),
        .s  (hi_s),
        .gm (hi_gm),
        .pm (hi_pm)
    );
`else
    logic hi_gm_unused;
    logic hi_pm_unused;

    add16 u_hi (
        .a  ({sa_q, a_hi_q}),
        .b  ({sb_q, b_hi_q}),
        .ci (c16_q),
        .s  (hi_s),
        .gm (hi_gm_unused),
        .pm (hi_pm_unused)
    );
`endif

    assign s2_free  = !out_valid_q || out_ready;
    assign s1_adv   = s1_valid_q && s2_free;
    assign in_ready = !s1_valid_q || s2_free;
    assign accept   = in_valid && in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        lo_sum_d   = lo_sum_q;
        c16_d      = c16_q;
        a_hi_d     = a_hi_q;
        b_hi_d     = b_hi_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            lo_sum_d   = lo_s;
            c16_d      = lo_gm | (lo_pm & c0);
            a_hi_d     = a[30:16];
            b_hi_d     = b_mod[30:16];
            sa_d       = a[31];
            sb_d       = b_mod[31];
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // A pop and a stage-2 load in the same cycle keep out_valid high.
    always_comb begin
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        if (s1_adv) begin
            out_valid_d = 1'b1;
            sum_d       = {hi_s, lo_sum_q};
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

`ifdef ADC32_FLAGS_EN
    always_comb begin
        flags_d = flags_q;
        if (s1_adv) begin
            flags_d[3] = hi_s[15];
            flags_d[2] = (hi_s == '0) && (lo_sum_q == '0);
            flags_d[1] = hi_gm | (hi_pm & c16_q);
            flags_d[0] = (sa_q == sb_q) && (hi_s[15] != sa_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flags_q <= '0;
        else        flags_q <= flags_d;
    end

    assign flags = flags_q;
`else
    assign flags = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            lo_sum_q    <= '0;
            c16_q       <= 1'b0;
            a_hi_q      <= '0;
            b_hi_q      <= '0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            lo_sum_q    <= lo_sum_d;
            c16_q       <= c16_d;
            a_hi_q      <= a_hi_d;
            b_hi_q      <= b_hi_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
endmodule

// File: tb/tb_adc32_pipe.sv
// Scoreboard bench for adc32_pipe. Inputs change on the falling edge; the
// monitor samples 4 time units after it (just before the next rising edge).
module tb_adc32_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [1:0]  op = 2'b00;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] sum;
    logic [3:0]  flags;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_ADC = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_SBB = 2'b11;

`ifdef ADC32_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    int pops = 0;
    logic [35:0] exp_q[$];

    adc32_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] ef(input logic [3:0] f);
        return FLAGS_ON ? f : 4'b0000;
    endfunction

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare every completed output transfer.
    initial begin
        logic [35:0] e;
        forever begin
            @(negedge clk);
            #4;
            if (rst_n && out_valid && out_ready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=%h required=none", {sum, flags});
                end else begin
                    e = exp_q.pop_front();
                    check("result", {sum, flags}, e);
                end
            end
        end
    end

    task automatic send(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic ci, input logic [31:0] es, input logic [3:0] f);
        int n;
        @(negedge clk);
        op = o; a = av; b = bv; cin = ci; in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=in_ready_0 required=in_ready_1");
        end else begin
            exp_q.push_back({es, ef(f)});
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain", 36'(exp_q.size()), 36'd0);
    endtask

    initial begin
        int idx;
        int p0;

        // Reset state.
        #1;
        check("rst_in_ready", 36'(in_ready), 36'd1);
        check("rst_out_valid", 36'(out_valid), 36'd0);
        check("rst_sum", 36'(sum), 36'd0);
        check("rst_flags", 36'(flags), 36'd0);

        // First accept on the first rising edge after release, latency 2.
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        op = OP_ADD; a = 32'h0000_FFFF; b = 32'h0000_0001; cin = 1'b0; in_valid = 1'b1;
        #1;
        check("first_accept", 36'(in_ready), 36'd1);
        exp_q.push_back({32'h0001_0000, ef(4'b0000)});
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("latency_n1", 36'(out_valid), 36'd0);
        @(negedge clk);
        #1;
        check("latency_n2", 36'(out_valid), 36'd1);

        // Directed vectors, issued back to back.
        send(OP_SUB, 32'd5,          32'd5,          1'b0, 32'h0000_0000, 4'b0110);
        send(OP_SUB, 32'd0,          32'd1,          1'b0, 32'hFFFF_FFFF, 4'b1000);
        send(OP_ADD, 32'h7FFF_FFFF,  32'd1,          1'b0, 32'h8000_0000, 4'b1001);
        send(OP_ADC, 32'hFFFF_FFFF,  32'd0,          1'b1, 32'h0000_0000, 4'b0110);
        send(OP_SBB, 32'd10,         32'd3,          1'b0, 32'h0000_0006, 4'b0010);
        send(OP_ADD, 32'd1,          32'd2,          1'b1, 32'h0000_0003, 4'b0000);
        send(OP_SUB, 32'd3,          32'd1,          1'b0, 32'h0000_0002, 4'b0010);
        send(OP_ADC, 32'h8000_0000,  32'h8000_0000,  1'b0, 32'h0000_0000, 4'b0111);
        idle();
        drain();

        // Back-pressure: only two operations fit while the output is stalled.
        out_ready = 1'b0;
        idx = 0;
        repeat (4) begin
            @(negedge clk);
            op = OP_ADD; cin = 1'b0;
            a = 32'(idx + 1); b = 32'(idx + 1); in_valid = 1'b1;
            #1;
            if (in_ready) begin
                exp_q.push_back({32'(2 * (idx + 1)), ef(4'b0000)});
                idx++;
            end
        end
        check("bp_accepted", 36'(idx), 36'd2);
        check("bp_in_ready", 36'(in_ready), 36'd0);
        p0 = pops;
        repeat (4) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (idx < 4) begin
                a = 32'(idx + 1); b = 32'(idx + 1); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back({32'(2 * (idx + 1)), ef(4'b0000)});
                idx++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("bp_pop_count", 36'(pops - p0), 36'd4);
        check("bp_no_dup", 36'(out_valid), 36'd0);
        check("bp_queue_empty", 36'(exp_q.size()), 36'd0);

        // Asynchronous reset with both stages occupied.
        out_ready = 1'b0;
        send(OP_ADD, 32'd100, 32'd1, 1'b0, 32'd101, 4'b0000);
        send(OP_ADD, 32'd200, 32'd2, 1'b0, 32'd202, 4'b0000);
        idle();
        #1;
        check("rst_pre_full", 36'({out_valid, in_ready}), 36'b10);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("rst_mid_out_valid", 36'(out_valid), 36'd0);
        check("rst_mid_sum", 36'(sum), 36'd0);
        check("rst_mid_flags", 36'(flags), 36'd0);
        check("rst_mid_in_ready", 36'(in_ready), 36'd1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        p0 = pops;
        repeat (5) @(negedge clk);
        #1;
        check("rst_no_stale_pops", 36'(pops - p0), 36'd0);
        check("rst_no_stale_valid", 36'(out_valid), 36'd0);

        // Pipeline still works after the reset.
        send(OP_ADD, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 4'b0000);
        idle();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule
